tt_um_uwasic_onboarding_nathan_thian_spec: RTL and testbench

TT_UM_UWASIC_ONBOARDING_NATHAN_THIAN_SPEC -- requirements
Module: tt_um_uwasic_onboarding_nathan_thian

---
 rtl/tt_um_uwasic_onboarding_nathan_thian_spec.sv | 132 +++++++++++++
 tb/tb_tt_um_uwasic_onboarding_nathan_thian_spec.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tt_um_uwasic_onboarding_nathan_thian_spec.sv
// SPI-programmed 16-channel output block: write-only register file feeding
// enable masks and a shared-phase PWM generator.
module tt_um_uwasic_onboarding_nathan_thian_spec #(
   parameter int unsigned PWM_PRESCALE = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned PreW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(PWM_PRESCALE - 1);

   // Synchronizer bit order: {ncs, copi, sclk}
   logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
   logic            sclk_prev_q, sclk_prev_d;
   logic            ncs_prev_q, ncs_prev_d;
   logic            active_q, active_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [15:0]     shift_q, shift_d;
   logic            commit_q, commit_d;
   logic [15:0]     en_out_q, en_out_d;
   logic [15:0]     en_pwm_q, en_pwm_d;
   logic [7:0]      duty_q, duty_d;
   logic [PreW-1:0] pre_q, pre_d;
   logic [7:0]      pwm_cnt_q, pwm_cnt_d;
   logic [15:0]     out_q, out_d;

   logic sclk_rise, ncs_fall, ncs_rise, pwm;
   logic unused_ok;

   assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

   assign sclk_rise = sync2_q[0] & ~sclk_prev_q;
   assign ncs_fall  = ~sync2_q[2] & ncs_prev_q;
   assign ncs_rise  = sync2_q[2] & ~ncs_prev_q;

   // Full-scale duty must stay high even though the counter reaches 255.
   assign pwm = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);

   always_comb begin
      sync1_d     = ui_in[2:0];
      sync2_d     = sync1_q;
      sclk_prev_d = sync2_q[0];
      ncs_prev_d  = sync2_q[2];
      active_d    = active_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      commit_d    = 1'b0;
      en_out_d    = en_out_q;
      en_pwm_d    = en_pwm_q;
      duty_d      = duty_q;

      // A frame only exists between an observed nCS fall and the next rise.
      if (ncs_fall) begin
         active_d = 1'b1;
         cnt_d    = 5'd0;
         shift_d  = 16'h0000;
      end else if (ncs_rise) begin
         active_d = 1'b0;
         commit_d = active_q && (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= 7'h04);
      end else if (active_q && sclk_rise) begin
         shift_d = {shift_q[14:0], sync2_q[1]};
         if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
      end

      if (commit_q) begin
         case (shift_q[10:8])
            3'd0:    en_out_d[7:0]  = shift_q[7:0];
            3'd1:    en_out_d[15:8] = shift_q[7:0];
            3'd2:    en_pwm_d[7:0]  = shift_q[7:0];
            3'd3:    en_pwm_d[15:8] = shift_q[7:0];
            3'd4:    duty_d         = shift_q[7:0];
            default: ;
         endcase
      end

      if (pre_q == PreMax) begin
         pre_d     = '0;
         pwm_cnt_d = pwm_cnt_q + 8'd1;
      end else begin
         pre_d     = pre_q + 1'b1;
         pwm_cnt_d = pwm_cnt_q;
      end

      out_d = en_out_q & (~en_pwm_q | {16{pwm}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 3'b000;
         sync2_q     <= 3'b000;
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b0;
         active_q    <= 1'b0;
         cnt_q       <= 5'd0;
         shift_q     <= 16'h0000;
         commit_q    <= 1'b0;
         en_out_q    <= 16'h0000;
         en_pwm_q    <= 16'h0000;
         duty_q      <= 8'h00;
         pre_q       <= '0;
         pwm_cnt_q   <= 8'h00;
         out_q       <= 16'h0000;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         sclk_prev_q <= sclk_prev_d;
         ncs_prev_q  <= ncs_prev_d;
         active_q    <= active_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         commit_q    <= commit_d;
         en_out_q    <= en_out_d;
         en_pwm_q    <= en_pwm_d;
         duty_q      <= duty_d;
         pre_q       <= pre_d;
         pwm_cnt_q   <= pwm_cnt_d;
         out_q       <= out_d;
      end
   end

   assign uo_out  = out_q[7:0];
   assign uio_out = out_q[15:8];
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_nathan_thian_spec.sv
// Directed bench: SPI register writes, discarded frames, PWM timing and reset.
`timescale 1ns/1ps
module tb_tt_um_uwasic_onboarding_nathan_thian_spec;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
   logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
   int         checks = 0;
   int         errors = 0;

   assign ui_in  = {5'b00000, ncs, copi, sclk};
   assign uio_in = 8'h00;

   tt_um_uwasic_onboarding_nathan_thian_spec dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (1'b1),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [15:0] word, input int n);
      for (int i = 0; i < n; i++) begin
         copi = word[15-i];
         wait_clk(4);
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
      wait_clk(4);
   endtask

   task automatic send_frame(input logic [15:0] word, input int n);
      ncs = 1'b0;
      wait_clk(4);
      spi_bits(word, n);
      ncs = 1'b1;
      wait_clk(10);
   endtask

   initial begin
      int high, low, ones, zeros;
      logic prev;
      logic found;

      wait_clk(5);
      check("rst_uo_out", {8'h00, uo_out}, 16'h0000);
      check("rst_uio_out", {8'h00, uio_out}, 16'h0000);
      check("rst_uio_oe", {8'h00, uio_oe}, 16'h00FF);
      rst_n = 1'b1;
      wait_clk(10);
      check("idle_uo_out", {8'h00, uo_out}, 16'h0000);
      check("idle_uio_out", {8'h00, uio_out}, 16'h0000);

      send_frame(16'h80F0, 16);
      check("w0_uo_out", {8'h00, uo_out}, 16'h00F0);
      check("w0_uio_out", {8'h00, uio_out}, 16'h0000);
      send_frame(16'h81CC, 16);
      check("w1_uio_out", {8'h00, uio_out}, 16'h00CC);
      check("w1_uo_out", {8'h00, uo_out}, 16'h00F0);

      send_frame(16'hB0AA, 16);
      check("badaddr", {uio_out, uo_out}, 16'hCCF0);
      send_frame(16'h0055, 16);
      check("read_frame", {uio_out, uo_out}, 16'hCCF0);
      send_frame(16'h85FF, 16);
      check("addr5", {uio_out, uo_out}, 16'hCCF0);

      // Channel 0 as PWM, 50% duty
      send_frame(16'h8201, 16);
      send_frame(16'h8480, 16);
      send_frame(16'h80F1, 16);
      check("pwm_upper_bits", {8'h00, uo_out & 8'hFE}, 16'h00F0);
      found = 1'b0;
      prev = uo_out[0];
      for (int i = 0; i < 4000 && !found; i++) begin
         wait_clk(1);
         if (!prev && uo_out[0]) found = 1'b1;
         prev = uo_out[0];
      end
      check("pwm_rise_found", {15'd0, found}, 16'd1);
      high = 0;
      low = 0;
      if (found) begin
         for (int i = 0; i < 4000 && uo_out[0]; i++) begin
            high++;
            wait_clk(1);
         end
         for (int i = 0; i < 4000 && !uo_out[0]; i++) begin
            low++;
            wait_clk(1);
         end
      end
      check("pwm_period", 16'(high + low), 16'd3328);
      check("pwm_high_50pct", {15'd0, (high >= 1651 && high <= 1677)}, 16'd1);

      send_frame(16'h8400, 16);
      ones = 0;
      for (int i = 0; i < 3400; i++) begin
         wait_clk(1);
         if (uo_out[0]) ones++;
      end
      check("duty00_ones", 16'(ones), 16'd0);
      send_frame(16'h84FF, 16);
      zeros = 0;
      for (int i = 0; i < 3400; i++) begin
         wait_clk(1);
         if (!uo_out[0]) zeros++;
      end
      check("dutyFF_zeros", 16'(zeros), 16'd0);

      send_frame(16'h8100, 12);
      check("short_frame", {8'h00, uio_out}, 16'h00CC);

      // Reset mid-frame, then clock a full frame with nCS never rising first
      ncs = 1'b0;
      wait_clk(4);
      spi_bits(16'h80FF, 8);
      rst_n = 1'b0;
      wait_clk(3);
      check("midrst_uo_out", {8'h00, uo_out}, 16'h0000);
      check("midrst_uio_out", {8'h00, uio_out}, 16'h0000);
      check("midrst_uio_oe", {8'h00, uio_oe}, 16'h00FF);
      rst_n = 1'b1;
      wait_clk(5);
      spi_bits(16'h80FF, 16);
      ncs = 1'b1;
      wait_clk(10);
      check("nofall_no_write", {uio_out, uo_out}, 16'h0000);

      send_frame(16'h803C, 16);
      check("recover_write", {uio_out, uo_out}, 16'h003C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
